// File: rtl/freq_sweep_if.sv
// freq_sweep_if
// Groups the signals between the NRx0/NRx3/NRx4 register file / frame
// sequencer (master side) and the frequency-sweep engine (slave side).
//   sweep_tick     : one-cycle sweep clock enable from the frame sequencer
//   trigger        : one-cycle channel restart pulse (NRx4[7] write)
//   freq_wr        : one-cycle CPU write of the frequency registers
//   freq_in        : CPU frequency word {NRx4[2:0], NRx3}
//   sweep_period   : NRx0 sweep time
//   sweep_negate   : NRx0 direction, 1 = decrease
//   sweep_shift    : NRx0 shift amount
//   freq_out       : working frequency to the waveform generator
//   freq_upd       : one-cycle pulse when the sweep rewrites freq_out
//   channel_enable : cleared when a sweep overflow disables the channel
interface freq_sweep_if #(
  parameter int FREQ_W   = 11,
  parameter int PERIOD_W = 3,
  parameter int SHIFT_W  = 3
);
  logic                sweep_tick;
  logic                trigger;
  logic                freq_wr;
  logic [FREQ_W-1:0]   freq_in;
  logic [PERIOD_W-1:0] sweep_period;
  logic                sweep_negate;
  logic [SHIFT_W-1:0]  sweep_shift;
  logic [FREQ_W-1:0]   freq_out;
  logic                freq_upd;
  logic                channel_enable;

  modport master (
    output sweep_tick, trigger, freq_wr, freq_in,
           sweep_period, sweep_negate, sweep_shift,
    input  freq_out, freq_upd, channel_enable
  );

  modport slave (
    input  sweep_tick, trigger, freq_wr, freq_in,
           sweep_period, sweep_negate, sweep_shift,
    output freq_out, freq_upd, channel_enable
  );
endinterface

// File: rtl/freq_sweep_unit.sv
// freq_sweep_unit
// Frequency-sweep engine for a square-wave sound channel. A shadow copy of
// the frequency is stepped by shadow>>shift (up or down) whenever the sweep
// timer expires; the result is pushed to the waveform generator and checked
// a second time one cycle later. Any overflow beyond the FREQ_W-bit range
// disables the channel.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset
//   bus   : freq_sweep_if slave modport (register-file inputs, sweep outputs)
module freq_sweep_unit #(
  parameter int FREQ_W       = 11,
  parameter int PERIOD_W     = 3,
  parameter int SHIFT_W      = 3,
  parameter bit NEGATE_QUIRK = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  freq_sweep_if.slave   bus
);

  typedef enum logic {IDLE, CHECK2} state_t;

  state_t              state_q, state_d;
  logic [FREQ_W-1:0]   shadow_q, shadow_d;
  logic [FREQ_W-1:0]   freq_out_q, freq_out_d;
  logic                freq_upd_q, freq_upd_d;
  logic                chan_en_q, chan_en_d;
  logic [PERIOD_W:0]   timer_q, timer_d;
  logic                sweep_en_q, sweep_en_d;
  logic                neg_used_q, neg_used_d;

  logic [FREQ_W:0]     calc_trig;
  logic [FREQ_W:0]     calc_shadow;
  logic [PERIOD_W:0]   reload;

  // One extra bit of headroom: bit FREQ_W set means the step overflowed.
  // The subtract path can never set it because shadow>>shift <= shadow.
  function automatic logic [FREQ_W:0] sweep_calc(
    input logic [FREQ_W-1:0]  sh,
    input logic [SHIFT_W-1:0] sft,
    input logic               neg
  );
    logic [FREQ_W:0] ext;
    logic [FREQ_W:0] delta;
    ext   = {1'b0, sh};
    delta = ext >> sft;
    return neg ? (ext - delta) : (ext + delta);
  endfunction

  assign calc_trig   = sweep_calc(bus.freq_in, bus.sweep_shift, bus.sweep_negate);
  assign calc_shadow = sweep_calc(shadow_q, bus.sweep_shift, bus.sweep_negate);

  // A period field of 0 behaves as the longest period, 2^PERIOD_W.
  assign reload = (bus.sweep_period == '0) ? {1'b1, {PERIOD_W{1'b0}}}
                                           : {1'b0, bus.sweep_period};

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    freq_out_d = freq_out_q;
    freq_upd_d = 1'b0;
    chan_en_d  = chan_en_q;
    timer_d    = timer_q;
    sweep_en_d = sweep_en_q;
    neg_used_d = neg_used_q;

    if (bus.trigger) begin
      // Restart wins over everything, including a pending second check.
      state_d    = IDLE;
      shadow_d   = bus.freq_in;
      freq_out_d = bus.freq_in;
      timer_d    = reload;
      neg_used_d = 1'b0;
      sweep_en_d = (bus.sweep_period != '0) || (bus.sweep_shift != '0);
      chan_en_d  = !((bus.sweep_shift != '0) && calc_trig[FREQ_W]);
    end else begin
      if (bus.freq_wr) begin
        freq_out_d = bus.freq_in;
      end

      unique case (state_q)
        CHECK2: begin
          // Look-ahead check of the freshly written shadow; no write-back.
          if (calc_shadow[FREQ_W]) begin
            chan_en_d = 1'b0;
          end
          if (bus.sweep_negate) begin
            neg_used_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: begin
          if (bus.sweep_tick) begin
            if (timer_q > (PERIOD_W+1)'(1)) begin
              timer_d = timer_q - (PERIOD_W+1)'(1);
            end else begin
              timer_d = reload;
              if (sweep_en_q && (bus.sweep_period != '0) && chan_en_q) begin
                if (bus.sweep_negate) begin
                  neg_used_d = 1'b1;
                end
                if (calc_shadow[FREQ_W]) begin
                  chan_en_d = 1'b0;
                end else if (bus.sweep_shift != '0) begin
                  shadow_d   = calc_shadow[FREQ_W-1:0];
                  freq_out_d = calc_shadow[FREQ_W-1:0];
                  freq_upd_d = 1'b1;
                  state_d    = CHECK2;
                end
              end
            end
          end
        end
      endcase

      // Switching from decrease to increase after a decrease was computed
      // kills the channel on the original hardware.
      if (NEGATE_QUIRK && neg_used_q && !bus.sweep_negate && chan_en_q) begin
        chan_en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      freq_out_q <= '0;
      freq_upd_q <= 1'b0;
      chan_en_q  <= 1'b0;
      timer_q    <= '0;
      sweep_en_q <= 1'b0;
      neg_used_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      freq_out_q <= freq_out_d;
      freq_upd_q <= freq_upd_d;
      chan_en_q  <= chan_en_d;
      timer_q    <= timer_d;
      sweep_en_q <= sweep_en_d;
      neg_used_q <= neg_used_d;
    end
  end

  assign bus.freq_out       = freq_out_q;
  assign bus.freq_upd       = freq_upd_q;
  assign bus.channel_enable = chan_en_q;

endmodule

// File: tb/tb_freq_sweep_unit.sv
// tb_freq_sweep_unit
// Drives a quirk-enabled and a quirk-disabled freq_sweep_unit from the same
// stimulus. Directed scenarios pin literal values; a random phase is checked
// every cycle against an arithmetic reference model of the sweep rules.
module tb_freq_sweep_unit;
  localparam int FW   = 11;
  localparam int PW   = 3;
  localparam int SW   = 3;
  localparam int MAXF = (1 << FW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic tick, trig, fwr, neg;
  logic [FW-1:0] fin;
  logic [PW-1:0] per;
  logic [SW-1:0] sft;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  freq_sweep_if #(.FREQ_W(FW), .PERIOD_W(PW), .SHIFT_W(SW)) ifa ();
  freq_sweep_if #(.FREQ_W(FW), .PERIOD_W(PW), .SHIFT_W(SW)) ifb ();

  assign ifa.sweep_tick   = tick;
  assign ifa.trigger      = trig;
  assign ifa.freq_wr      = fwr;
  assign ifa.freq_in      = fin;
  assign ifa.sweep_period = per;
  assign ifa.sweep_negate = neg;
  assign ifa.sweep_shift  = sft;
  assign ifb.sweep_tick   = tick;
  assign ifb.trigger      = trig;
  assign ifb.freq_wr      = fwr;
  assign ifb.freq_in      = fin;
  assign ifb.sweep_period = per;
  assign ifb.sweep_negate = neg;
  assign ifb.sweep_shift  = sft;

  freq_sweep_unit #(.FREQ_W(FW), .PERIOD_W(PW), .SHIFT_W(SW), .NEGATE_QUIRK(1'b1))
    dut_q (.clock(clk), .reset(rst), .bus(ifa));
  freq_sweep_unit #(.FREQ_W(FW), .PERIOD_W(PW), .SHIFT_W(SW), .NEGATE_QUIRK(1'b0))
    dut_n (.clock(clk), .reset(rst), .bus(ifb));

  // Reference model: index 0 has the negate quirk, index 1 does not.
  int m_fo[2], m_sh[2], m_tmr[2];
  bit m_upd[2], m_en[2], m_swp[2], m_nu[2], m_chk2[2];

  function automatic int step_of(int sh);
    int d;
    d = sh >> sft;
    return neg ? (sh - d) : (sh + d);
  endfunction

  always @(posedge clk) begin
    int  r, c;
    bit  en_prev, nu_prev;
    for (int k = 0; k < 2; k++) begin
      r       = (per == 0) ? (1 << PW) : int'(per);
      en_prev = m_en[k];
      nu_prev = m_nu[k];
      m_upd[k] = 1'b0;
      if (rst) begin
        m_fo[k] = 0; m_sh[k] = 0; m_tmr[k] = 0;
        m_en[k] = 0; m_swp[k] = 0; m_nu[k] = 0; m_chk2[k] = 0;
      end else if (trig) begin
        m_sh[k]   = int'(fin);
        m_fo[k]   = int'(fin);
        m_tmr[k]  = r;
        m_nu[k]   = 0;
        m_swp[k]  = (per != 0) || (sft != 0);
        m_en[k]   = !((sft != 0) && (step_of(int'(fin)) > MAXF));
        m_chk2[k] = 0;
      end else begin
        if (fwr) m_fo[k] = int'(fin);
        if (m_chk2[k]) begin
          m_chk2[k] = 0;
          if (step_of(m_sh[k]) > MAXF) m_en[k] = 0;
          if (neg) m_nu[k] = 1;
        end else if (tick) begin
          if (m_tmr[k] > 1) begin
            m_tmr[k]--;
          end else begin
            m_tmr[k] = r;
            if (m_swp[k] && per != 0 && en_prev) begin
              c = step_of(m_sh[k]);
              if (neg) m_nu[k] = 1;
              if (c > MAXF) begin
                m_en[k] = 0;
              end else if (sft != 0) begin
                m_sh[k] = c; m_fo[k] = c; m_upd[k] = 1; m_chk2[k] = 1;
              end
            end
          end
        end
        if (k == 0 && nu_prev && !neg && en_prev) m_en[k] = 0;
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      n_tests++;
      if ({ifa.freq_out, ifa.freq_upd, ifa.channel_enable} !==
          {FW'(m_fo[0]), m_upd[0], m_en[0]}) begin
        n_fail++;
        $display("FAIL model_quirk t=%0t got fo=%h upd=%b en=%b want fo=%h upd=%b en=%b",
                 $time, ifa.freq_out, ifa.freq_upd, ifa.channel_enable,
                 FW'(m_fo[0]), m_upd[0], m_en[0]);
      end
      n_tests++;
      if ({ifb.freq_out, ifb.freq_upd, ifb.channel_enable} !==
          {FW'(m_fo[1]), m_upd[1], m_en[1]}) begin
        n_fail++;
        $display("FAIL model_noquirk t=%0t got fo=%h upd=%b en=%b want fo=%h upd=%b en=%b",
                 $time, ifb.freq_out, ifb.freq_upd, ifb.channel_enable,
                 FW'(m_fo[1]), m_upd[1], m_en[1]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trig = 1'b1; step(); trig = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  initial begin
    int gap;
    bit seen_upd;
    rst = 1'b1; tick = 0; trig = 0; fwr = 0; neg = 0; fin = '0; per = '0; sft = '0;
    step(); step();
    chk_on = 1'b1;
    chk("reset_fo", ifa.freq_out, 0);
    chk("reset_upd", ifa.freq_upd, 0);
    chk("reset_en", ifa.channel_enable, 0);
    rst = 1'b0;
    step();

    // Add with overflow on the second check
    fin = 11'h400; per = 3'd1; sft = 3'd1; neg = 0;
    pulse_trig();
    chk("add_trig_en", ifa.channel_enable, 1);
    chk("add_trig_fo", ifa.freq_out, 'h400);
    pulse_tick();
    chk("add_tick_fo", ifa.freq_out, 'h600);
    chk("add_tick_upd", ifa.freq_upd, 1);
    chk("add_tick_en", ifa.channel_enable, 1);
    step();
    chk("add_chk2_en", ifa.channel_enable, 0);
    chk("add_chk2_upd", ifa.freq_upd, 0);

    // Decrease with period 2
    fin = 11'h100; per = 3'd2; sft = 3'd2; neg = 1;
    pulse_trig(); step();
    pulse_tick(); step();
    chk("dec_tick1_fo", ifa.freq_out, 'h100);
    pulse_tick();
    chk("dec_tick2_fo", ifa.freq_out, 'h0C0);
    step(); pulse_tick(); step(); pulse_tick();
    chk("dec_tick4_fo", ifa.freq_out, 'h090);
    chk("dec_tick4_en", ifa.channel_enable, 1);
    step();

    // Immediate overflow at trigger
    neg = 0; step();
    fin = 11'h7FF; sft = 3'd1; per = 3'd1;
    pulse_trig();
    chk("ovf_trig_en", ifa.channel_enable, 0);
    seen_upd = ifa.freq_upd;
    for (int i = 0; i < 6; i++) begin
      pulse_tick(); seen_upd |= ifa.freq_upd; step(); seen_upd |= ifa.freq_upd;
    end
    chk("ovf_no_upd", seen_upd, 0);
    chk("ovf_fo", ifa.freq_out, 'h7FF);

    // No-op sweep with shift 0
    fin = 11'h234; sft = 3'd0; per = 3'd3;
    pulse_trig();
    seen_upd = 0;
    for (int i = 0; i < 20; i++) begin
      pulse_tick(); seen_upd |= ifa.freq_upd; step(); seen_upd |= ifa.freq_upd;
    end
    chk("noop_fo", ifa.freq_out, 'h234);
    chk("noop_en", ifa.channel_enable, 1);
    chk("noop_no_upd", seen_upd, 0);
    fin = 11'h111; fwr = 1; step(); fwr = 0;
    chk("noop_fwr_fo", ifa.freq_out, 'h111);
    chk("noop_fwr_upd", ifa.freq_upd, 0);

    // Negate quirk
    fin = 11'h200; neg = 1; sft = 3'd1; per = 3'd1;
    pulse_trig();
    pulse_tick();
    chk("quirk_tick_fo", ifa.freq_out, 'h100);
    step();
    neg = 0;
    step();
    chk("quirk_en_q", ifa.channel_enable, 0);
    chk("quirk_en_noq", ifb.channel_enable, 1);
    step();

    // Reset during CHECK2
    fin = 11'h400; per = 3'd1; sft = 3'd1; neg = 0;
    pulse_trig();
    pulse_tick();
    rst = 1; step(); rst = 0;
    chk("rst_chk2_fo", ifa.freq_out, 0);
    chk("rst_chk2_en", ifa.channel_enable, 0);
    chk("rst_chk2_upd", ifa.freq_upd, 0);

    // Trigger during CHECK2 aborts the pending overflow check
    pulse_trig();
    pulse_tick();
    fin = 11'h050;
    pulse_trig();
    chk("trig_chk2_fo", ifa.freq_out, 'h050);
    chk("trig_chk2_en", ifa.channel_enable, 1);
    step();
    chk("trig_chk2_idle_en", ifa.channel_enable, 1);

    // Randomised phase
    gap = 0;
    for (int i = 0; i < 4000; i++) begin
      tick = (gap >= 1) && ($urandom_range(0, 2) == 0);
      gap  = tick ? 0 : gap + 1;
      trig = ($urandom_range(0, 39) == 0);
      fwr  = !tick && ($urandom_range(0, 29) == 0);
      rst  = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 15) == 0) neg = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) per = PW'($urandom_range(0, (1 << PW) - 1));
      if ($urandom_range(0, 31) == 0) sft = SW'($urandom_range(0, (1 << SW) - 1));
      fin = ($urandom_range(0, 3) == 0) ? FW'($urandom_range(0, MAXF))
                                        : FW'($urandom_range(0, 'h3FF));
      step();
    end
    tick = 0; trig = 0; fwr = 0; rst = 0;
    step();
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/freq_sweep_unit.md
Name: freq_sweep_unit

Overview:
- Parametrised frequency-sweep engine for a square-wave sound channel (GB/GBA channel 1 style).
- Keeps a shadow frequency and steps it up or down by shadow>>shift on each expiry of a programmable sweep timer.
- Drives the channel's working frequency and disables the channel on overflow.
- Sits between the NRx0/NRx3/NRx4 register file and the square-wave generator. Advances on a one-cycle `sweep_tick` enable from the frame sequencer.

Parameters:
- FREQ_W, 11, width of the frequency word and shadow register.
- PERIOD_W, 3, width of the sweep period field and sweep timer.
- SHIFT_W, 3, width of the sweep shift field.
- NEGATE_QUIRK, 1, when 1, clearing negate after a negate-mode calculation disables the channel.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sweep_tick  in  1  one-cycle sweep clock enable (128 Hz rate).
- trigger  in  1  one-cycle pulse on a channel restart (NRx4[7] write).
- freq_wr  in  1  one-cycle pulse on a CPU write of the frequency registers.
- freq_in  in  FREQ_W  CPU frequency value {NRx4[2:0], NRx3}.
- sweep_period  in  PERIOD_W  NRx0 sweep time.
- sweep_negate  in  1  NRx0 direction; 1 = decrease.
- sweep_shift  in  SHIFT_W  NRx0 shift amount.
- freq_out  out  FREQ_W  working frequency to the waveform generator.
- freq_upd  out  1  one-cycle pulse when the sweep writes freq_out.
- channel_enable  out  1  0 when disabled by a sweep overflow.

Behaviour:
- Arithmetic:
  - calc = negate ? shadow - (shadow>>shift) : shadow + (shadow>>shift), computed FREQ_W+1 bits wide.
  - Overflow when calc > 2^FREQ_W-1. Subtraction never overflows.
- Reset: freq_out=0, freq_upd=0, channel_enable=0, shadow=0, timer=0, sweep_en=0, neg_used=0, state=IDLE.
- Registered state: shadow[FREQ_W], timer[PERIOD_W+1], sweep_en, neg_used, state in {IDLE, CHECK2}.
- Reload value R = (sweep_period==0) ? 2^PERIOD_W : sweep_period.
- freq_wr with no trigger: freq_out<=freq_in next cycle. Shadow is untouched. No freq_upd.
- trigger (highest priority after reset, aborts CHECK2 and returns to IDLE):
  - shadow<=freq_in, freq_out<=freq_in, timer<=R, neg_used<=0.
  - sweep_en<=(sweep_period!=0 || sweep_shift!=0).
  - channel_enable<=1, unless sweep_shift!=0 and calc (computed from freq_in) overflows; then channel_enable<=0.
- IDLE with sweep_tick:
  - timer>1: timer decrements.
  - Otherwise timer<=R. If sweep_en && sweep_period!=0 && channel_enable, evaluate calc:
    - Overflow: channel_enable<=0, state stays IDLE.
    - No overflow and sweep_shift!=0: shadow<=calc, freq_out<=calc, freq_upd=1 in the next cycle, state<=CHECK2.
    - No overflow and sweep_shift==0: no frequency change.
  - neg_used<=1 if sweep_negate was used in any calc performed.
- CHECK2, one cycle:
  - Recompute calc from the new shadow (no write-back).
  - Overflow sets channel_enable<=0.
  - state<=IDLE.
- Latency: a tick in cycle t updates freq_out/freq_upd at t+1. Second-check disable is visible at t+2.
- sweep_tick arriving in CHECK2 is dropped. Ticks are contractually ≥2 cycles apart.
- NEGATE_QUIRK=1: neg_used && !sweep_negate && channel_enable drives channel_enable<=0 the next cycle.
- NRx0 fields are sampled live. A period change takes effect at the next reload.
- freq_wr and trigger in the same cycle: the trigger rules apply.

Test Plan:
- Add with overflow on second check: freq_in=0x400, period=1, shift=1, negate=0, trigger.
  - channel_enable=1.
  - First tick → freq_out=0x600 with freq_upd pulse.
  - Second check (0x900) → channel_enable=0 two cycles after the tick.
- Decrease with period 2: freq_in=0x100, period=2, negate=1, shift=2, trigger.
  - First tick → no change.
  - Second tick → freq_out=0x0C0.
  - Fourth tick → freq_out=0x090.
- Immediate overflow at trigger: freq_in=0x7FF, shift=1, negate=0 → channel_enable=0 one cycle after trigger. No freq_upd ever.
- No-op sweep: shift=0, period=3, freq_in=0x234, 20 ticks → freq_out stays 0x234, channel_enable=1, no freq_upd. A freq_wr of 0x111 → freq_out=0x111 next cycle.
- Negate quirk: NEGATE_QUIRK=1, freq_in=0x200, negate=1, shift=1, period=1.
  - One tick → freq_out=0x100.
  - Clear negate → channel_enable=0 next cycle.
  - With NEGATE_QUIRK=0 the channel stays enabled.
- Reset and trigger during CHECK2:
  - Assert reset in the CHECK2 cycle → all outputs 0 next cycle.
  - Separately, trigger in CHECK2 with freq_in=0x050 → freq_out=0x050, channel_enable=1, state IDLE.
